// File: rtl/count_mon_pkg.sv
// Shared encodings for the count monitor.
// Holds the FSM states and the step-class codes.
package count_mon_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DOWN = 2'd1,
    HOLD = 2'd2,
    SKIP = 2'd3
  } step_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/count_step_classify.sv
// Classifies one counter step from the modular delta.
// Wrap-around steps fall out of the mod-2^BITS subtraction.
module count_step_classify
  import count_mon_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] count_in,
  input  logic [BITS-1:0] prev,
  output step_t           step
);

  localparam logic [BITS-1:0] ONE = BITS'(1);
  localparam logic [BITS-1:0] ALL = '1;

  logic [BITS-1:0] delta;

  assign delta = count_in - prev;

  // Map the delta onto one of the four step classes
  always_comb begin
    step = SKIP;
    if (delta == '0)
      step = HOLD;
    else if (delta == ONE)
      step = UP;
    else if (delta == ALL)
      step = DOWN;
  end

endmodule

// File: rtl/count_monitor.sv
// Tracks a far-end up/down counter: lock, direction,
// illegal steps and stalls, all outputs registered.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int BITS        = 4,
  parameter int STALL_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] count_in,
  input  logic            valid_in,
  output logic            locked,
  output logic            dir_up,
  output logic            dir_change,
  output logic            err_skip,
  output logic            stalled,
  output logic [7:0]      err_count
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t          state, state_n;
  step_t           step;
  logic [BITS-1:0] prev, prev_n;
  logic [7:0]      hold_run, hold_n;
  logic            skip_run, skip_n;
  logic            dir_n, chg_n, skp_n;
  logic [7:0]      errc_n;

  count_step_classify #(.BITS(BITS)) u_classify (
    .count_in (count_in),
    .prev     (prev),
    .step     (step)
  );

  // State and history registers; reset discards all history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      prev       <= '0;
      hold_run   <= '0;
      skip_run   <= 1'b0;
      dir_up     <= 1'b1;
      dir_change <= 1'b0;
      err_skip   <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      hold_run   <= hold_n;
      skip_run   <= skip_n;
      dir_up     <= dir_n;
      dir_change <= chg_n;
      err_skip   <= skp_n;
      err_count  <= errc_n;
    end
  end

  // Next state, run counters and pulses for each valid sample
  always_comb begin
    state_n = state;
    prev_n  = prev;
    hold_n  = hold_run;
    skip_n  = skip_run;
    dir_n   = dir_up;
    chg_n   = 1'b0;
    skp_n   = 1'b0;
    errc_n  = err_count;
    if (valid_in) begin
      prev_n = count_in;
      unique case (state)
        EMPTY: state_n = ACQUIRE;
        ACQUIRE: begin
          if (step == UP || step == DOWN) begin
            dir_n   = (step == UP);
            state_n = LOCKED;
            hold_n  = '0;
            skip_n  = 1'b0;
          end
        end
        LOCKED: begin
          hold_n = '0;
          skip_n = 1'b0;
          unique case (step)
            UP, DOWN: begin
              if ((step == UP) != dir_up) begin
                dir_n = ~dir_up;
                chg_n = 1'b1;
              end
            end
            HOLD: begin
              if (hold_run < LIMIT)
                hold_n = hold_run + 8'd1;
              else
                hold_n = hold_run;
            end
            SKIP: begin
              skp_n = 1'b1;
              if (err_count != ERR_MAX)
                errc_n = err_count + 8'd1;
              if (skip_run)
                state_n = ACQUIRE;
              else
                skip_n = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  assign locked  = (state == LOCKED);
  assign stalled = (hold_run >= LIMIT);

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor (BITS=4, STALL_LIMIT=3).
// Each step is one valid sample; outputs checked 1ns after the edge.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = '0;
  logic       valid_in = 1'b0;
  logic       locked, dir_up, dir_change, err_skip, stalled;
  logic [7:0] err_count;

  int total  = 0;
  int passed = 0;

  count_monitor #(.BITS(4), .STALL_LIMIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .valid_in   (valid_in),
    .locked     (locked),
    .dir_up     (dir_up),
    .dir_change (dir_change),
    .err_skip   (err_skip),
    .stalled    (stalled),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic [3:0] v);
    @(negedge clk);
    count_in = v;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_locked"}, locked, 1'b0);
    chk1({tag, "_dir_up"}, dir_up, 1'b1);
    chk1({tag, "_dir_change"}, dir_change, 1'b0);
    chk1({tag, "_err_skip"}, err_skip, 1'b0);
    chk1({tag, "_stalled"}, stalled, 1'b0);
    chk8({tag, "_err_count"}, err_count, 8'd0);
  endtask

  initial begin
    #12;
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    step(4'd3);
    chk1("s3_locked", locked, 1'b0);
    step(4'd4);
    chk1("s4_locked", locked, 1'b1);
    chk1("s4_dir_up", dir_up, 1'b1);
    chk1("s4_err_skip", err_skip, 1'b0);
    step(4'd5);
    chk1("s5_err_skip", err_skip, 1'b0);
    step(4'd6);
    chk1("s6_err_skip", err_skip, 1'b0);

    for (int v = 7; v < 18; v++) begin
      step(4'(v % 16));
      chk1("wrap_err_skip", err_skip, 1'b0);
      chk1("wrap_dir_up", dir_up, 1'b1);
      chk1("wrap_locked", locked, 1'b1);
    end

    for (int v = 2; v < 8; v++) step(4'(v));
    chk1("at7_dir_change", dir_change, 1'b0);
    step(4'd6);
    chk1("rev_dir_change", dir_change, 1'b1);
    chk1("rev_dir_up", dir_up, 1'b0);
    chk1("rev_locked", locked, 1'b1);
    step(4'd5);
    chk1("rev2_dir_change", dir_change, 1'b0);
    chk1("rev2_dir_up", dir_up, 1'b0);

    step(4'd9);
    chk1("skip1_err_skip", err_skip, 1'b1);
    chk8("skip1_err_count", err_count, 8'd1);
    chk1("skip1_locked", locked, 1'b1);
    step(4'd12);
    chk1("skip2_err_skip", err_skip, 1'b1);
    chk8("skip2_err_count", err_count, 8'd2);
    chk1("skip2_locked", locked, 1'b0);
    step(4'd13);
    chk1("relock_locked", locked, 1'b1);
    chk1("relock_dir_up", dir_up, 1'b1);
    chk1("relock_dir_change", dir_change, 1'b0);
    chk1("relock_err_skip", err_skip, 1'b0);

    @(posedge clk);
    #1;
    chk1("idle_locked", locked, 1'b1);
    chk8("idle_err_count", err_count, 8'd2);
    chk1("idle_err_skip", err_skip, 1'b0);

    step(4'd12);
    chk1("down_dir_change", dir_change, 1'b1);
    for (int v = 11; v >= 8; v--) step(4'(v));
    chk1("at8_dir_up", dir_up, 1'b0);
    step(4'd8);
    chk1("hold1_stalled", stalled, 1'b0);
    step(4'd8);
    chk1("hold2_stalled", stalled, 1'b0);
    step(4'd8);
    chk1("hold3_stalled", stalled, 1'b1);
    chk1("hold3_locked", locked, 1'b1);
    step(4'd9);
    chk1("unstall_stalled", stalled, 1'b0);
    chk1("unstall_dir_change", dir_change, 1'b1);
    chk1("unstall_err_skip", err_skip, 1'b0);

    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step(4'd10);
    chk1("post_rst_locked", locked, 1'b0);
    step(4'd11);
    chk1("post_rst_relock", locked, 1'b1);
    chk8("post_rst_err_count", err_count, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
